// File: rtl/k_fifo_wr_arbiter.sv
// k_fifo_wr_arbiter
// Write side of an asynchronous FIFO shared by two requesters.
// A round-robin arbiter picks at most one writer per cycle, the write
// pointer is kept in Gray code for the read domain, and the full flag is
// computed against a two-flop synchronized copy of the read pointer.
module k_fifo_wr_arbiter #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0,
   input  logic [DATA_W-1:0] din0,
   input  logic              req1,
   input  logic [DATA_W-1:0] din1,
   output logic              gnt0,
   output logic              gnt1,
   output logic              wen,
   output logic [ADDR_W-1:0] waddr,
   output logic [DATA_W-1:0] wdata,
   output logic [ADDR_W:0]   wptr_gray,
   input  logic [ADDR_W:0]   rptr_gray,
   output logic              full
);

   // Gray code to binary: each binary bit is the XOR of all Gray bits above and at it
   function automatic logic [ADDR_W:0] gray2bin(input logic [ADDR_W:0] g);
      logic [ADDR_W:0] b;
      b[ADDR_W] = g[ADDR_W];
      for (int i = ADDR_W - 1; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   // Binary to Gray code
   function automatic logic [ADDR_W:0] bin2gray(input logic [ADDR_W:0] b);
      return b ^ (b >> 1);
   endfunction

   // Full when the writer is exactly one lap ahead: top two Gray bits differ, rest equal
   function automatic logic is_full(input logic [ADDR_W:0] wg, input logic [ADDR_W:0] rg);
      return (wg == {~rg[ADDR_W:ADDR_W-1], rg[ADDR_W-2:0]});
   endfunction

   logic [ADDR_W:0] ptr_gray_r;
   logic [ADDR_W:0] rq1_r;
   logic [ADDR_W:0] rq2_r;
   logic            full_r;
   logic            last_r;      // index of the last granted requester

   logic [ADDR_W:0] bin_s;
   logic [ADDR_W:0] next_bin_s;
   logic [ADDR_W:0] next_gray_s;
   logic            full_next_s;
   logic            gnt0_s;
   logic            gnt1_s;
   logic            wen_s;
   logic [DATA_W-1:0] wdata_s;

   // Round-robin grant; reset and full both suppress any grant immediately
   always_comb begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
      if (!rst_n || full_r) begin
         gnt0_s = 1'b0;
         gnt1_s = 1'b0;
      end else begin
         case ({req1, req0})
            2'b01: gnt0_s = 1'b1;
            2'b10: gnt1_s = 1'b1;
            2'b11: begin
               if (last_r) begin
                  gnt0_s = 1'b1;
               end else begin
                  gnt1_s = 1'b1;
               end
            end
            default: begin
               gnt0_s = 1'b0;
               gnt1_s = 1'b0;
            end
         endcase
      end
   end

   // Write data mux and pointer arithmetic for the next state
   always_comb begin
      wen_s = gnt0_s | gnt1_s;
      if (gnt0_s) begin
         wdata_s = din0;
      end else if (gnt1_s) begin
         wdata_s = din1;
      end else begin
         wdata_s = {DATA_W{1'b0}};
      end
      bin_s       = gray2bin(ptr_gray_r);
      next_bin_s  = bin_s + {{ADDR_W{1'b0}}, wen_s};
      next_gray_s = bin2gray(next_bin_s);
      full_next_s = is_full(next_gray_s, rq2_r);
   end

   // Gray write pointer register; advances by one on each accepted write
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_gray_r <= {(ADDR_W+1){1'b0}};
      end else begin
         ptr_gray_r <= next_gray_s;
      end
   end

   // Two-flop synchronizer for the read pointer from the other clock domain
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rq1_r <= {(ADDR_W+1){1'b0}};
         rq2_r <= {(ADDR_W+1){1'b0}};
      end else begin
         rq1_r <= rptr_gray;
         rq2_r <= rq1_r;
      end
   end

   // Registered full flag, reflecting this cycle's write and the synced read pointer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         full_r <= 1'b0;
      end else begin
         full_r <= full_next_s;
      end
   end

   // Last-winner tracking; reset value makes requester 0 win the first tie
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_r <= 1'b1;
      end else if (wen_s) begin
         last_r <= gnt1_s;
      end else begin
         last_r <= last_r;
      end
   end

   assign gnt0      = gnt0_s;
   assign gnt1      = gnt1_s;
   assign wen       = wen_s;
   assign waddr     = bin_s[ADDR_W-1:0];
   assign wdata     = wdata_s;
   assign wptr_gray = ptr_gray_r;
   assign full      = full_r;

endmodule

// File: tb/tb_k_fifo_wr_arbiter.sv
// Self-checking bench for k_fifo_wr_arbiter (defaults DATA_W=8, ADDR_W=4).
// A count-based model (writes so far, synchronized reader count) predicts
// every output each cycle; directed literal checks pin the model.
module tb_k_fifo_wr_arbiter;
   logic       clk = 1'b0;
   logic       rst_n;
   logic       req0, req1;
   logic [7:0] din0, din1;
   logic       gnt0, gnt1, wen, full;
   logic [3:0] waddr;
   logic [7:0] wdata;
   logic [4:0] wptr_gray;
   logic [4:0] rptr_gray;
   logic [4:0] rcnt;

   int total = 0;
   int bad   = 0;

   // model state: write count, reader count after two sync stages, full, last winner
   logic [4:0] m_w, m_r1, m_r2;
   logic       m_full;
   logic       m_last;

   // bookkeeping for the tracking phase
   logic [3:0] prev_addr;
   logic       prev_g0;
   int         seen_top, seen_wrap, full_seen;

   always #5 clk = ~clk;

   k_fifo_wr_arbiter #(.DATA_W(8), .ADDR_W(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0(req0), .din0(din0), .req1(req1), .din1(din1),
      .gnt0(gnt0), .gnt1(gnt1), .wen(wen), .waddr(waddr), .wdata(wdata),
      .wptr_gray(wptr_gray), .rptr_gray(rptr_gray), .full(full)
   );

   function automatic logic [4:0] g5(input logic [4:0] b);
      return b ^ (b >> 1);
   endfunction

   assign rptr_gray = g5(rcnt);

   // expected grants from the arbitration rules
   function automatic logic eg0();
      return rst_n && !m_full && req0 && (!req1 || m_last);
   endfunction
   function automatic logic eg1();
      return rst_n && !m_full && req1 && (!req0 || !m_last);
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // model update: count writes, full when writer is 16 ahead of the synced reader
   always @(posedge clk or negedge rst_n) begin
      logic       g0, g1;
      logic [4:0] nw;
      if (!rst_n) begin
         m_w    <= 5'd0;
         m_r1   <= 5'd0;
         m_r2   <= 5'd0;
         m_full <= 1'b0;
         m_last <= 1'b1;
      end else begin
         g0 = eg0();
         g1 = eg1();
         nw = m_w + {4'd0, g0 | g1};
         m_w    <= nw;
         m_full <= ((nw - m_r2) == 5'd16);
         m_r2   <= m_r1;
         m_r1   <= rcnt;
         if (g0 | g1) m_last <= g1;
      end
   end

   // compare every output against the model each cycle
   always @(negedge clk) begin
      check("gnt0", {31'd0, gnt0}, {31'd0, eg0()});
      check("gnt1", {31'd0, gnt1}, {31'd0, eg1()});
      check("wen", {31'd0, wen}, {31'd0, eg0() | eg1()});
      check("waddr", {28'd0, waddr}, {28'd0, m_w[3:0]});
      check("wdata", {24'd0, wdata}, {24'd0, eg0() ? din0 : (eg1() ? din1 : 8'd0)});
      check("wptr_gray", {27'd0, wptr_gray}, {27'd0, g5(m_w)});
      check("full", {31'd0, full}, {31'd0, m_full});
   end

   initial begin
      rst_n = 1'b0; req0 = 1'b1; req1 = 1'b1; din0 = 8'hA0; din1 = 8'h50; rcnt = 5'd0;
      // reset with both requests pending
      repeat (2) @(negedge clk);
      check("rst_gnt0", {31'd0, gnt0}, 32'd0);
      check("rst_wen", {31'd0, wen}, 32'd0);
      check("rst_full", {31'd0, full}, 32'd0);
      check("rst_wptr", {27'd0, wptr_gray}, 32'd0);
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      check("first_gnt0", {31'd0, gnt0}, 32'd1);
      check("first_wdata", {24'd0, wdata}, 32'hA0);
      // both requesting: alternate 0,1,0,...
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1 din0 = 8'(8'h10 + i); din1 = 8'(8'hE0 - i);
         @(negedge clk);
         check("alt_gnt0", {31'd0, gnt0}, (i % 2 == 1) ? 32'd1 : 32'd0);
         check("alt_wdata", {24'd0, wdata}, (i % 2 == 1) ? {24'd0, din0} : {24'd0, din1});
      end
      // seven writes done, then asynchronous reset mid-cycle
      @(posedge clk); #2;
      check("w7_wptr", {27'd0, wptr_gray}, 32'h04);
      rst_n = 1'b0;
      #1;
      check("arst_gnt0", {31'd0, gnt0}, 32'd0);
      check("arst_gnt1", {31'd0, gnt1}, 32'd0);
      check("arst_wen", {31'd0, wen}, 32'd0);
      check("arst_wptr", {27'd0, wptr_gray}, 32'd0);
      check("arst_full", {31'd0, full}, 32'd0);
      req1 = 1'b0;
      @(negedge clk);
      @(posedge clk); #1 rst_n = 1'b1;
      // fill: 16 grants to requester 0 at waddr 0..15
      for (int i = 0; i < 16; i++) begin
         if (i > 0) begin
            @(posedge clk); #1 din0 = 8'(i * 7);
         end
         @(negedge clk);
         check("fill_waddr", {28'd0, waddr}, i);
         check("fill_gnt0", {31'd0, gnt0}, 32'd1);
      end
      @(negedge clk);
      check("full_set", {31'd0, full}, 32'd1);
      check("full_wptr", {27'd0, wptr_gray}, 32'h18);
      check("full_gnt0", {31'd0, gnt0}, 32'd0);
      repeat (3) @(negedge clk);
      check("full_hold", {31'd0, gnt0}, 32'd0);
      // reader advances by one: full falls after the third edge
      @(posedge clk); #1 rcnt = 5'd1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("full_still", {31'd0, full}, 32'd1);
      @(posedge clk);
      @(negedge clk);
      check("full_fell", {31'd0, full}, 32'd0);
      check("wait_gnt0", {31'd0, gnt0}, 32'd1);
      @(negedge clk);
      check("full_again", {31'd0, full}, 32'd1);
      // reader catches up; then requester 1 alone, then nobody
      @(posedge clk); #1 rcnt = m_w; req0 = 1'b0; req1 = 1'b1; din1 = 8'h3C;
      repeat (6) @(posedge clk);
      #1 req1 = 1'b0; rcnt = m_w;
      repeat (4) @(posedge clk);
      #1 rcnt = m_w;
      repeat (3) @(posedge clk);
      // reader tracks writer through 40 alternating writes
      #1 req0 = 1'b1; req1 = 1'b1;
      seen_top = 0; seen_wrap = 0; full_seen = 0;
      for (int i = 0; i < 40; i++) begin
         if (i > 0) begin
            @(posedge clk); #1 rcnt = m_w;
            din0 = 8'($urandom_range(255, 0)); din1 = 8'($urandom_range(255, 0));
         end
         @(negedge clk);
         check("trk_wen", {31'd0, wen}, 32'd1);
         if (full) full_seen++;
         if (i > 0) begin
            check("trk_addr", {28'd0, waddr}, {28'd0, 4'(prev_addr + 4'd1)});
            check("trk_alt", {31'd0, gnt0}, {31'd0, ~prev_g0});
         end
         if (wptr_gray == 5'b10000) seen_top = 1;
         if (seen_top == 1 && wptr_gray == 5'b00000) seen_wrap = 1;
         prev_addr = waddr;
         prev_g0   = gnt0;
      end
      check("trk_no_full", full_seen, 32'd0);
      check("trk_seen_top", seen_top, 32'd1);
      check("trk_seen_wrap", seen_wrap, 32'd1);
      @(posedge clk); #1 req0 = 1'b0; req1 = 1'b0;
      repeat (2) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
